mult_rr_sched: RTL and testbench

- Round-robin scheduler sharing one sequential 4x4 multiplier (mult4x4_seq) among NREQ requesters.
- Accepts operand pairs over a per-requester valid/ready handshake and sequences the multiplier's start/done protocol.
- Returns each product tagged with the requester ID.
- Sits between the requester logic and a single mult4x4_seq instance; the multiplier is instantiated outside this block.

---
 rtl/mult_sched_pkg.sv | 17 +
 rtl/mult_rr_sched_rr_pick.sv | 40 ++++
 rtl/mult_rr_sched.sv | 132 +++++++++++++
 tb/tb_mult_rr_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types and defaults for the multiplier scheduler.
// Holds the FSM state encoding, default sizes and timeout counter width.
package mult_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int TOCNT_W   = 8;

endpackage

// File: rtl/mult_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin arbiter.
// Rotates the request vector past the last grant, then priority-encodes.
module rr_pick
    import mult_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any_valid
);

    localparam int IDW = $clog2(NREQ);
    localparam int OW  = IDW + 1;

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [OW-1:0]     start;
    logic [OW-1:0]     off;
    logic [OW-1:0]     sum;

    always_comb begin
        any_valid = |req;
        start = (last >= IDW'(NREQ - 1)) ? '0 : OW'(last) + OW'(1);
        dbl = {req, req} >> start;
        rot = dbl[NREQ-1:0];
        off = '0;
        // Lowest set bit of the rotated vector is the nearest requester
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = OW'(i);
        end
        sum = start + off;
        if (sum >= OW'(NREQ)) sum = sum - OW'(NREQ);
        idx = sum[IDW-1:0];
        grant = any_valid ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mult_rr_sched.sv
// mult_rr_sched: round-robin front end sharing one sequential multiplier.
// Define MULT_TIMEOUT_EN to add the WAIT abort counter and resp_err.
module mult_rr_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ           = DEF_NREQ,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IDW           = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [2*WIDTH-1:0]    resp_product,
`ifdef MULT_TIMEOUT_EN
    output logic                  resp_err,
`endif
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_product,
    input  logic                  mul_done
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("mult_rr_sched: NREQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_to
        $error("mult_rr_sched: TIMEOUT_CYCLES must be 1..256");
    end

    state_t           state;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   id;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic             any_valid;
    logic [WIDTH-1:0] a_sl [NREQ];
    logic [WIDTH-1:0] b_sl [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_sl[i] = req_a[i*WIDTH +: WIDTH];
        assign b_sl[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req       (req_valid),
        .last      (last),
        .grant     (grant),
        .idx       (gidx),
        .any_valid (any_valid)
    );

    assign req_ready = (state == S_IDLE && !rst) ? grant : '0;

`ifdef MULT_TIMEOUT_EN
    logic [TOCNT_W-1:0] cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            last         <= IDW'(NREQ - 1);
            id           <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_product <= '0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
`ifdef MULT_TIMEOUT_EN
            resp_err     <= 1'b0;
            cnt          <= '0;
`endif
        end else begin
            mul_start  <= 1'b0;
            resp_valid <= 1'b0;
`ifdef MULT_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        mul_a     <= a_sl[gidx];
                        mul_b     <= b_sl[gidx];
                        id        <= gidx;
                        last      <= gidx;
                        mul_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_ARM;
                // Done may still be high from the previous operation here
                S_ARM: begin
`ifdef MULT_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        resp_product <= mul_product;
                        resp_id      <= id;
                        resp_valid   <= 1'b1;
                        state        <= S_RESP;
                    end
`ifdef MULT_TIMEOUT_EN
                    else if (cnt == TOCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_product <= '0;
                        resp_id      <= id;
                        resp_valid   <= 1'b1;
                        resp_err     <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt + TOCNT_W'(1);
                    end
`endif
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_sched.sv
// tb_mult_rr_sched: directed plus random checks of the shared-multiplier scheduler.
// Includes a behavioural multiplier with adjustable latency, stale-done and hang modes.
module tb_mult_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [2*W-1:0]    resp_product;
`ifdef MULT_TIMEOUT_EN
    logic              resp_err;
`endif
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_product;
    logic              mul_done;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit pend [NREQ];
    int op_a [NREQ];
    int op_b [NREQ];
    int last;
    int last_grant;

    // Multiplier model controls
    int   mlat  = 2;
    bit   stale = 1'b0;
    bit   never = 1'b0;
    bit   mbusy;
    int   mcnt;
    logic [W-1:0] na, nb;

    int nstart = 0;
    int nresp  = 0;

    mult_rr_sched #(
        .NREQ           (NREQ),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_product (resp_product),
`ifdef MULT_TIMEOUT_EN
        .resp_err     (resp_err),
`endif
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .mul_done     (mul_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            mbusy       <= 1'b0;
            mcnt        <= 0;
        end else if (mul_start) begin
            mbusy <= 1'b1;
            mcnt  <= mlat;
            na    <= mul_a;
            nb    <= mul_b;
            if (!stale) mul_done <= 1'b0;
        end else if (mbusy) begin
            mul_done <= 1'b0;
            if (mcnt == 0) begin
                if (!never) begin
                    mul_done    <= 1'b1;
                    mul_product <= {4'b0, na} * {4'b0, nb};
                    mbusy       <= 1'b0;
                end
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mul_start) nstart++;
        if (resp_valid) nresp++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = W'(op_a[i]);
            req_b[i*W +: W]    = W'(op_b[i]);
        end
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        pend[i] = 1'b1;
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
        never = 1'b0;
        stale = 1'b0;
        mlat  = 2;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        last = NREQ - 1;
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (|req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_seen", 0, 1);
    endtask

    task automatic serve_one(input bit keep0, input bit drop_en);
        int g, ea, eb, j;
        bit ok;
        wait_accept(ok);
        if (!ok) return;
        g = model_grant();
        chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
        if (g < 0) return;
        ea = op_a[g];
        eb = op_b[g];
        last = g;
        last_grant = g;
        if (keep0 && g == 0) begin
            op_a[0] = $urandom_range(15);
            op_b[0] = $urandom_range(15);
        end else begin
            pend[g] = 1'b0;
        end
        @(negedge clk);
        drive();
        #1;
        chk("mul_start_on", mul_start, 1);
        chk("ready_busy", req_ready, 0);
        chk("mul_a", mul_a, ea);
        chk("mul_b", mul_b, eb);
        @(negedge clk);
        #1;
        chk("mul_start_off", mul_start, 0);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            chk("resp_seen", 0, 1);
            return;
        end
        chk("resp_id", resp_id, g);
        chk("resp_product", resp_product, ea * eb);
`ifdef MULT_TIMEOUT_EN
        chk("resp_err_clear", resp_err, 0);
`endif
        if (drop_en) begin
            j = $urandom_range(NREQ - 1);
            if (pend[j] && $urandom_range(3) == 0) begin
                pend[j] = 1'b0;
                drive();
            end
        end
        @(negedge clk);
        #1;
        chk("resp_pulse", resp_valid, 0);
        chk("prod_hold", resp_product, ea * eb);
    endtask

    initial begin
        int s0, r0, lat;
        int gseq [4];
        bit ok;
        int exp_seq [4];
        exp_seq = '{0, 1, 0, 0};

        // Reset state
        do_reset();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_product", resp_product, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);

        // Single request from requester 2
        @(negedge clk);
        set_req(2, 3, 5);
        drive();
        serve_one(1'b0, 1'b0);
        chk("single_id", last_grant, 2);

        // All four at once after reset: strict order 0..3
        do_reset();
        set_req(0, 7, 9);
        set_req(1, 15, 15);
        set_req(2, 2, 8);
        set_req(3, 0, 13);
        drive();
        s0 = nstart;
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b0, 1'b0);
            chk("all4_order", last_grant, i);
        end
        chk("all4_starts", nstart - s0, 4);

        // Fairness: requester 0 held, requester 1 asserted once
        do_reset();
        set_req(0, 1, 2);
        set_req(1, 3, 4);
        drive();
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b1, 1'b0);
            gseq[i] = last_grant;
        end
        for (int i = 0; i < 4; i++) chk("fair_seq", gseq[i], exp_seq[i]);
        pend[0] = 1'b0;
        drive();

        // Reset while waiting on the multiplier
        do_reset();
        mlat = 10;
        set_req(0, 6, 7);
        drive();
        wait_accept(ok);
        chk("rstwait_grant", req_ready, 1);
        pend[0] = 1'b0;
        last = 0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
        @(negedge clk);
        #1;
        chk("abort_req_ready", req_ready, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_resp_id", resp_id, 0);
        chk("abort_resp_product", resp_product, 0);
        chk("abort_mul_start", mul_start, 0);
        chk("abort_mul_a", mul_a, 0);
        chk("abort_mul_b", mul_b, 0);
        rst = 1'b0;
        last = NREQ - 1;
        mlat = 2;
        r0 = nresp;
        repeat (12) @(negedge clk);
        #1;
        chk("abort_no_resp", nresp - r0, 0);
        set_req(0, 4, 4);
        set_req(3, $urandom_range(15), $urandom_range(15));
        drive();
        serve_one(1'b0, 1'b0);
        chk("prio_restored", last_grant, 0);
        serve_one(1'b0, 1'b0);

        // Stale done from the previous operation
        do_reset();
        stale = 1'b1;
        set_req(1, 5, 9);
        drive();
        serve_one(1'b0, 1'b0);
        set_req(2, 11, 13);
        drive();
        serve_one(1'b0, 1'b0);
        stale = 1'b0;

        // Random traffic with occasional withdrawals
        do_reset();
        for (int r = 0; r < 25; r++) begin
            mlat = $urandom_range(4);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(1) == 1)
                    set_req(i, $urandom_range(15), $urandom_range(15));
            end
            drive();
            for (int n = 0; n < 2 * NREQ; n++) begin
                if (model_grant() < 0) break;
                serve_one(1'b0, 1'b1);
            end
        end

`ifdef MULT_TIMEOUT_EN
        // Hung multiplier: abort after 8 WAIT cycles
        do_reset();
        never = 1'b1;
        set_req(1, 3, 3);
        drive();
        wait_accept(ok);
        chk("to_grant", req_ready, 2);
        pend[1] = 1'b0;
        last = 1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) drive();
            #1;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        chk("to_latency", lat, 11);
        chk("to_err", resp_err, 1);
        chk("to_product", resp_product, 0);
        chk("to_id", resp_id, 1);
        never = 1'b0;
        @(negedge clk);
        set_req(2, 9, 7);
        drive();
        serve_one(1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
